// File: rtl/play_engine_pkg.sv
// Shared audio defines: chunk map, controller state encodings and the play engine state type.
package play_engine_pkg;

  localparam int unsigned SramAddrW   = 23;
  localparam int unsigned NumChunks   = 4;
  localparam int unsigned CHUNK_LEN   = 262144;

  // Chunk base word addresses in SRAM.
  localparam logic [SramAddrW-1:0] ChunkBase [NumChunks] = '{
    23'h000000, 23'h040000, 23'h080000, 23'h0C0000
  };

  typedef enum logic [1:0] {
    CtrlIdle,
    CtrlRecord,
    CtrlPlay,
    CtrlErase
  } ctrl_state_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StReady,
    StDone,
    StRelease
  } play_state_t;

  function automatic logic [SramAddrW-1:0] chunk_base(input logic [1:0] idx);
    return ChunkBase[idx];
  endfunction

endpackage

// File: rtl/play_engine.sv
// Play handshake responder: fetches one SRAM chunk word by word and hands each
// sample to the DAC path on its frame strobe.
module play_engine
  import play_engine_pkg::*;
#(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LEN_W     = 20,
  parameter int unsigned CHUNK_LEN = play_engine_pkg::CHUNK_LEN
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic              play_stop,
  input  logic              play_pause,
  output logic              play_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dac_req,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid,
  output logic [7:0]        o_underrun,
  output logic              o_busy
);

  play_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic [7:0]        under_q, under_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic              stop_req;

  // Losing the start level is treated exactly like an explicit stop.
  assign stop_req = play_stop | ~play_start;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ptr_d       = ptr_q;
    buf_d       = buf_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    under_d     = under_q;
    stop_pend_d = stop_pend_q;
    done_d      = (state_q == StDone);
    mem_req     = 1'b0;
    mem_addr    = '0;

    unique case (state_q)
      StIdle: begin
        if (play_start) begin
          base_d      = play_select;
          ptr_d       = '0;
          under_d     = 8'd0;
          stop_pend_d = 1'b0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        mem_req  = 1'b1;
        mem_addr = base_q + ADDR_W'(ptr_q);
        if (stop_req) stop_pend_d = 1'b1;
        if (dac_req && !play_pause && (under_q != 8'hFF)) under_d = under_q + 8'd1;
        // The request is completed even when a stop arrives mid-transaction.
        if (mem_ack) begin
          buf_d   = mem_rdata;
          ptr_d   = ptr_q + LEN_W'(1);
          state_d = (stop_pend_q || stop_req) ? StDone : StReady;
        end
      end
      StReady: begin
        if (stop_req) begin
          state_d = StDone;
        end else if (!play_pause && dac_req) begin
          sample_d = buf_q;
          valid_d  = 1'b1;
          state_d  = (ptr_q == LEN_W'(CHUNK_LEN)) ? StDone : StFetch;
        end
      end
      StDone: begin
        sample_d = '0;
        state_d  = StRelease;
      end
      StRelease: begin
        // Hold off until the controller drops start so it cannot retrigger.
        if (!play_start) begin
          stop_pend_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      ptr_q       <= '0;
      buf_q       <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      under_q     <= 8'd0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      ptr_q       <= ptr_d;
      buf_q       <= buf_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      under_q     <= under_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  assign play_done  = done_q;
  assign o_sample   = sample_q;
  assign o_valid    = valid_q;
  assign o_underrun = under_q;
  assign o_busy     = (state_q == StFetch) || (state_q == StReady);

endmodule

// File: tb/tb_play_engine.sv
// Self-checking bench for play_engine: table-driven sessions, directed corner
// cases and randomized sessions against a sample-availability model.
module tb_play_engine;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 20;
  localparam int          CHUNK  = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              play_start, play_stop, play_pause;
  logic [ADDR_W-1:0] play_select;
  logic              play_done;
  logic              mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              dac_req;
  logic [DATA_W-1:0] o_sample;
  logic              o_valid;
  logic [7:0]        o_underrun;
  logic              o_busy;

  play_engine #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .CHUNK_LEN(CHUNK)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .play_start (play_start),
    .play_select(play_select),
    .play_stop  (play_stop),
    .play_pause (play_pause),
    .play_done  (play_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .dac_req    (dac_req),
    .o_sample   (o_sample),
    .o_valid    (o_valid),
    .o_underrun (o_underrun),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs
  int   ack_delay, dac_period, req_cnt, cyc;
  bit   start_k, stop_k, pause_k, dac_force, ack_seen;
  logic [ADDR_W-1:0] sel_k;

  // Reference model: a sample is either waiting or not; a strobe either takes it or underruns.
  bit                m_on;
  int                m_acks, m_served, m_under;
  logic [DATA_W-1:0] m_last_data, m_sample;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] g_last_addr;
  logic [DATA_W-1:0] g_last_sample;

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                delay;
    int                period;
    int                pause_rate;
    int                min_under;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_sample;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, respond, model, then check after the edge.
  task automatic step();
    bit exp_v;
    play_start  = start_k;
    play_stop   = stop_k;
    play_pause  = pause_k;
    play_select = sel_k;
    if (dac_force) dac_req = 1'b1;
    else if (dac_period > 0) dac_req = ((cyc % dac_period) == (dac_period - 1));
    else dac_req = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    ack_seen  = 1'b0;
    #1;
    if (mem_req) begin
      if (req_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hA000 + mem_addr[15:0];
        req_cnt   = 0;
        ack_seen  = 1'b1;
      end else begin
        req_cnt++;
      end
    end
    exp_v = 1'b0;
    if (m_on) begin
      if (dac_req && !pause_k) begin
        if (m_acks > m_served) begin
          exp_v    = 1'b1;
          m_sample = m_last_data;
          m_served++;
        end else if (m_under < 255) begin
          m_under++;
        end
      end
      if (mem_ack) begin
        if (exp_addr.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        else chk("unexpected fetch", 32'(mem_addr), 32'hFFFF_FFFF);
        g_last_addr = mem_addr;
        m_acks++;
        m_last_data = mem_rdata;
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_valid) g_last_sample = o_sample;
    if (m_on) begin
      chk("o_valid", 32'(o_valid), 32'(exp_v));
      chk("o_sample", 32'(o_sample), 32'(m_sample));
      chk("o_underrun", 32'(o_underrun), 32'(m_under));
      chk("play_done early", 32'(play_done), 32'd0);
      if (m_served == CHUNK) m_on = 1'b0;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #3;
    i_rst   = 1'b0;
    start_k = 1'b0;
    stop_k  = 1'b0;
    pause_k = 1'b0;
    m_on    = 1'b0;
    req_cnt = 0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] base);
    exp_addr.delete();
    for (int i = 0; i < CHUNK; i++) exp_addr.push_back(base + ADDR_W'(i));
    req_cnt  = 0;
    m_acks   = 0;
    m_served = 0;
    m_under  = 0;
    m_sample = '0;
    m_on     = 1'b0;
    sel_k    = base;
    start_k  = 1'b1;
    stop_k   = 1'b0;
    pause_k  = 1'b0;
    step();
    sel_k = ~base;  // must be ignored for the rest of the session
    chk("start->mem_req", 32'(mem_req), 32'd1);
    m_on = 1'b1;
  endtask

  task automatic finish_session(input int pause_rate);
    int n = 0;
    while (m_on && n < 3000) begin
      pause_k = (pause_rate > 0) && ($urandom_range(0, 99) < pause_rate);
      step();
      n++;
    end
    pause_k = 1'b0;
    if (m_on) begin
      chk("session timeout", 32'd1, 32'd0);
      do_reset();
      return;
    end
    step();
    chk("play_done after last sample", 32'(play_done), 32'd1);
    chk("silence after done", 32'(o_sample), 32'd0);
    chk("busy after done", 32'(o_busy), 32'd0);
    step();
    chk("play_done single pulse", 32'(play_done), 32'd0);
    chk("all words fetched", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic hold_release(input int n);
    repeat (n) begin
      step();
      chk("no retrigger mem_req", 32'(mem_req), 32'd0);
      chk("no retrigger busy", 32'(o_busy), 32'd0);
    end
    start_k = 1'b0;
    step();
    step();
  endtask

  initial begin
    int n, vcnt, dcnt, rcnt, saved;
    vecs[0] = '{23'h000100, 2, 10, 0, 0, 23'h000103, 16'hA103};
    vecs[1] = '{23'h000100, 2, 7, 0, 0, 23'h000103, 16'hA103};
    vecs[2] = '{23'h7FFFFE, 2, 10, 0, 0, 23'h000001, 16'hA001};
    vecs[3] = '{23'h000100, 30, 10, 0, 2, 23'h000103, 16'hA103};

    i_rst = 1'b1;
    {play_start, play_stop, play_pause, mem_ack, dac_req} = '0;
    play_select = '0;
    mem_rdata   = '0;
    {start_k, stop_k, pause_k, dac_force, m_on} = '0;
    sel_k = '0;
    ack_delay = 2; dac_period = 10; req_cnt = 0; cyc = 0;
    @(posedge i_clk);
    #1;
    chk("reset play_done", 32'(play_done), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset o_sample", 32'(o_sample), 32'd0);
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_underrun", 32'(o_underrun), 32'd0);
    chk("reset o_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    step();
    step();

    for (int v = 0; v < 4; v++) begin
      ack_delay  = vecs[v].delay;
      dac_period = vecs[v].period;
      start_session(vecs[v].base);
      finish_session(vecs[v].pause_rate);
      chk("last mem_addr", 32'(g_last_addr), 32'(vecs[v].last_addr));
      chk("last sample", 32'(g_last_sample), 32'(vecs[v].last_sample));
      if (vecs[v].min_under > 0)
        chk("underrun during stall", 32'(o_underrun >= 8'(vecs[v].min_under)), 32'd1);
      hold_release(5);
    end

    // Pause in READY: strobes ignored, sample held until pause drops.
    ack_delay = 1; dac_period = 10;
    start_session(23'h000200);
    n = 0;
    while (m_acks == m_served && n < 100) begin step(); n++; end
    pause_k = 1'b1;
    saved = m_under;
    vcnt = 0;
    repeat (30) begin step(); vcnt += int'(o_valid); end
    chk("no o_valid while paused", 32'(vcnt), 32'd0);
    chk("underrun frozen while paused", 32'(o_underrun), 32'(saved));
    pause_k = 1'b0;
    n = 0;
    while (m_served == 0 && n < 20) begin step(); n++; end
    chk("buffered sample after pause", 32'(g_last_sample), 32'hA200);
    finish_session(0);
    hold_release(2);

    // Stop while a read is outstanding: request held to ack, then one done.
    m_on = 1'b0; ack_delay = 5; dac_period = 0; req_cnt = 0;
    start_k = 1'b1; sel_k = 23'h000400;
    step();
    chk("stop seq mem_req", 32'(mem_req), 32'd1);
    stop_k = 1'b1;
    n = 0;
    ack_seen = 1'b0;
    while (!ack_seen && n < 20) begin
      step();
      n++;
      if (!ack_seen) chk("mem_req held on stop", 32'(mem_req), 32'd1);
    end
    chk("stop seq ack arrived", 32'(ack_seen), 32'd1);
    dcnt = 0; rcnt = 0;
    repeat (10) begin step(); dcnt += int'(play_done); rcnt += int'(mem_req); end
    chk("stop seq done pulses", 32'(dcnt), 32'd1);
    chk("stop seq no further req", 32'(rcnt), 32'd0);
    stop_k = 1'b0; start_k = 1'b0;
    step();
    step();

    // Stop and dac_req together in READY: stop wins.
    ack_delay = 0; dac_period = 0; req_cnt = 0;
    start_k = 1'b1;
    step();
    n = 0;
    while (!(o_busy && !mem_req) && n < 20) begin step(); n++; end
    stop_k = 1'b1; dac_force = 1'b1;
    step();
    dac_force = 1'b0;
    chk("stop beats dac_req", 32'(o_valid), 32'd0);
    step();
    chk("stop in READY done", 32'(play_done), 32'd1);
    stop_k = 1'b0; start_k = 1'b0;
    step();
    step();

    // Asynchronous reset in FETCH with a live sample on the output.
    ack_delay = 3; dac_period = 4;
    start_session(23'h000300);
    n = 0;
    while (!(o_valid && mem_req) && n < 100) begin step(); n++; end
    chk("pre-reset sample", 32'(o_sample), 32'hA300);
    i_rst = 1'b1;
    #2;
    chk("async rst mem_req", 32'(mem_req), 32'd0);
    chk("async rst o_busy", 32'(o_busy), 32'd0);
    chk("async rst o_sample", 32'(o_sample), 32'd0);
    chk("async rst o_valid", 32'(o_valid), 32'd0);
    chk("async rst mem_addr", 32'(mem_addr), 32'd0);
    m_on = 1'b0; start_k = 1'b0; play_start = 1'b0;
    i_rst = 1'b0;
    req_cnt = 0;
    @(posedge i_clk);
    #1;
    step();

    for (int r = 0; r < 6; r++) begin
      ack_delay  = $urandom_range(0, 12);
      dac_period = $urandom_range(2, 15);
      start_session(ADDR_W'($urandom));
      finish_session($urandom_range(0, 30));
      hold_release(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
